riscv_counter_bank: RTL

//  Bank of NUM_CNT independent WIDTH-bit event counters (mcycle/minstret/mhpmcounterN style) with a CSR

---
 rtl/riscv_cnt_pkg.sv | 14 +
 rtl/riscv_cnt_slice.sv | 52 +++++
 rtl/riscv_counter_bank.sv | 85 ++++++++
 3 files changed

// File: rtl/riscv_cnt_pkg.sv
// Shared types and constants for the RISC-V event counter bank.
// Overflow interrupt support is enabled by defining RISCV_CNT_OVF_IRQ_EN.
package riscv_cnt_pkg;

  typedef enum logic [1:0] {
    HALF_NONE = 2'b00,
    HALF_LO   = 2'b01,
    HALF_HI   = 2'b10,
    HALF_ALL  = 2'b11
  } cnt_half_e;

  localparam logic [127:0] CNT_RST_VAL = '0;

endpackage

// File: rtl/riscv_cnt_slice.sv
// One event counter: half-write mux, increment adder, inhibit gate.
// The carry-out port exists only when RISCV_CNT_OVF_IRQ_EN is defined.
module riscv_cnt_slice
  import riscv_cnt_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int INC_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [INC_W-1:0] inc,
  input  logic             inh,
  input  logic             wr_en,
  input  logic [1:0]       wr_mask,
  input  logic [WIDTH-1:0] wr_data,
`ifdef RISCV_CNT_OVF_IRQ_EN
  output logic             carry,
`endif
  output logic [WIDTH-1:0] cnt
);

  localparam int HALF = WIDTH / 2;

  logic [WIDTH:0] sum;
  logic           wr_hit;

  assign sum    = {1'b0, cnt} + {{(WIDTH + 1 - INC_W){1'b0}}, inc};
  assign wr_hit = wr_en && (wr_mask != 2'b00);

`ifdef RISCV_CNT_OVF_IRQ_EN
  // A write takes priority, so a dropped increment never overflows.
  assign carry = sum[WIDTH] && !inh && !wr_hit;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= CNT_RST_VAL[WIDTH-1:0];
    end else if (wr_en) begin
      unique case (cnt_half_e'(wr_mask))
        HALF_LO:  cnt[HALF-1:0]     <= wr_data[HALF-1:0];
        HALF_HI:  cnt[WIDTH-1:HALF] <= wr_data[WIDTH-1:HALF];
        HALF_ALL: cnt               <= wr_data;
        default: begin
          if (!inh) cnt <= sum[WIDTH-1:0];
        end
      endcase
    end else if (!inh) begin
      cnt <= sum[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/riscv_counter_bank.sv
// Bank of event counters with CSR write/read ports and inhibit mask.
// Define RISCV_CNT_OVF_IRQ_EN to add overflow flags and interrupt.
module riscv_counter_bank
  import riscv_cnt_pkg::*;
#(
  parameter int NUM_CNT = 4,
  parameter int WIDTH   = 64,
  parameter int INC_W   = 2,
  parameter int AW      = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CNT*INC_W-1:0] inc_vec,
  input  logic                     wr_en,
  input  logic [AW-1:0]            wr_addr,
  input  logic [1:0]               wr_mask,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     inh_wr_en,
  input  logic [NUM_CNT-1:0]       inh_wr_data,
  output logic [NUM_CNT-1:0]       inh_mask,
`ifdef RISCV_CNT_OVF_IRQ_EN
  input  logic [NUM_CNT-1:0]       ovf_clr,
  output logic [NUM_CNT-1:0]       ovf_flags,
  output logic                     ovf_irq,
`endif
  input  logic [AW-1:0]            rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0]   cnt [NUM_CNT];
  logic [WIDTH-1:0]   rd_mux;
`ifdef RISCV_CNT_OVF_IRQ_EN
  logic [NUM_CNT-1:0] carry;
`endif

  for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
    riscv_cnt_slice #(
      .WIDTH (WIDTH),
      .INC_W (INC_W)
    ) u_slice (
      .clk     (clk),
      .rst     (rst),
      .inc     (inc_vec[i*INC_W +: INC_W]),
      .inh     (inh_mask[i]),
      .wr_en   (wr_en && (wr_addr == AW'(i))),
      .wr_mask (wr_mask),
      .wr_data (wr_data),
`ifdef RISCV_CNT_OVF_IRQ_EN
      .carry   (carry[i]),
`endif
      .cnt     (cnt[i])
    );
  end

  // Unmapped addresses match no slice and read back as zero.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (rd_addr == AW'(i)) rd_mux = cnt[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data <= '0;
    else     rd_data <= rd_mux;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            inh_mask <= '0;
    else if (inh_wr_en) inh_mask <= inh_wr_data;
  end

`ifdef RISCV_CNT_OVF_IRQ_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_flags <= '0;
      ovf_irq   <= 1'b0;
    end else begin
      ovf_flags <= (ovf_flags & ~ovf_clr) | carry;
      ovf_irq   <= |(ovf_flags & ~inh_mask);
    end
  end
`endif

endmodule
